// File: rtl/aes_inv_key_expand_if.sv
// Request / round-key stream bundle between the AES-128 decrypt key generator
// and its consumer. The master drives start, key_in and rk_ready; the slave is the generator.
interface aes_inv_key_expand_if;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         done;

  modport master (
    output start, key_in, rk_ready,
    input  busy, rk_valid, rk_out, rk_round, done
  );

  modport slave (
    input  start, key_in, rk_ready,
    output busy, rk_valid, rk_out, rk_round, done
  );
endinterface

// File: rtl/aes_inv_key_expand.sv
// AES-128 decrypt round-key generator: 10-cycle forward walk to round 10, then keys 10..0 streamed.
// One key per accepted handshake; rk_ready low freezes key, round and valid. Outputs come from registers only.

module aes_inv_key_expand_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y_o = SBOX[a_i];
endmodule

module aes_inv_key_expand (
  input  logic                   clk,
  input  logic                   rst,
  aes_inv_key_expand_if.slave    bus_if
);
  typedef enum logic [1:0] {IDLE, FWD, REV, FIN} state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [127:0]   key_q, key_d;

  logic [31:0]    k0, k1, k2, k3;
  logic [31:0]    p1, p2, p3;
  logic [31:0]    sub_src, rot_w, sub_w, rcon_w;
  logic [127:0]   fwd_key, prev_key;
  logic           xfer;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  assign k0 = key_q[127:96];
  assign k1 = key_q[95:64];
  assign k2 = key_q[63:32];
  assign k3 = key_q[31:0];

  assign p3 = k3 ^ k2;
  assign p2 = k2 ^ k1;
  assign p1 = k1 ^ k0;

  // Forward step substitutes k3, backward step substitutes the recovered p3: one S-box set serves both.
  assign sub_src = (state_q == REV) ? p3 : k3;
  assign rot_w   = {sub_src[23:0], sub_src[31:24]};
  assign rcon_w  = {rcon(cnt_q), 24'h000000};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_inv_key_expand_sbox u_sbox (
      .a_i (rot_w[8*i +: 8]),
      .y_o (sub_w[8*i +: 8])
    );
  end

  always_comb begin
    logic [31:0] n0, n1, n2, n3;
    n0       = k0 ^ sub_w ^ rcon_w;
    n1       = k1 ^ n0;
    n2       = k2 ^ n1;
    n3       = k3 ^ n2;
    fwd_key  = {n0, n1, n2, n3};
    prev_key = {k0 ^ sub_w ^ rcon_w, p1, p2, p3};
  end

  assign xfer = (state_q == REV) && bus_if.rk_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    unique case (state_q)
      IDLE: begin
        if (bus_if.start) begin
          key_d   = bus_if.key_in;
          cnt_d   = 4'd1;
          state_d = FWD;
        end
      end
      FWD: begin
        key_d = fwd_key;
        if (cnt_q == 4'd10) begin
          state_d = REV;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      REV: begin
        if (xfer) begin
          if (cnt_q == 4'd0) begin
            state_d = FIN;
          end else begin
            key_d = prev_key;
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Key and round are masked outside REV so the stream reads zero whenever nothing is offered.
  always_comb begin
    bus_if.busy     = (state_q != IDLE);
    bus_if.rk_valid = (state_q == REV);
    bus_if.rk_out   = (state_q == REV) ? key_q : '0;
    bus_if.rk_round = (state_q == REV) ? cnt_q : 4'd0;
    bus_if.done     = (state_q == FIN);
  end
endmodule

// File: tb/tb_aes_inv_key_expand.sv
// Directed bench for the AES-128 decrypt key generator using FIPS-197 and all-zero key vectors.
`define CHK(TAG, O, E) begin tests++; assert ((O) === (E)) else begin fails++; $error("FAIL %s observed=%0h expected=%0h", TAG, (O), (E)); end end

module tb_aes_inv_key_expand;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  logic [127:0] exp_rk    [0:10];
  bit           exp_known [0:10];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_KEY = 128'h0;

  aes_inv_key_expand_if bus ();

  aes_inv_key_expand dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  always #5 clk = ~clk;

  task automatic load_fips();
    exp_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int i = 0; i <= 10; i++) exp_known[i] = 1'b1;
  endtask

  task automatic load_zero();
    for (int i = 0; i <= 10; i++) begin
      exp_known[i] = 1'b0;
      exp_rk[i]    = '0;
    end
    exp_rk[0]     = 128'h0;
    exp_rk[1]     = 128'h62636363626363636263636362636363;
    exp_rk[10]    = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    exp_known[0]  = 1'b1;
    exp_known[1]  = 1'b1;
    exp_known[10] = 1'b1;
  endtask

  // Called at a negedge in IDLE; returns at the first negedge with rk_valid high (or on timeout).
  task automatic start_seq(input logic [127:0] k, input bit inject);
    int lat;
    bus.start  = 1'b1;
    bus.key_in = k;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.key_in = ~k;
    lat = 0;
    `CHK("busy_after_start", bus.busy, 1'b1)
    while (!bus.rk_valid && lat < 40) begin
      bus.start = inject && (lat == 3);
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    tests++;
    if (lat >= 40) begin
      fails++;
      $error("FAIL valid_timeout: rk_valid not seen within %0d cycles", lat);
    end
    `CHK("valid_latency", lat, 10)
  endtask

  // mode 0: ready held high; mode 1: random ready with a 5-cycle stall at round 6.
  // stop_at >= 0 returns while that round is being offered; otherwise runs through FIN into IDLE.
  task automatic collect(input int mode, input int stop_at, input bit inject);
    int           exp_r;
    int           stall_left;
    bit           stalled;
    bit           rdy;
    logic [127:0] h_out;
    logic [3:0]   h_rnd;
    exp_r      = 10;
    stall_left = 5;
    stalled    = 1'b0;
    h_out      = '0;
    h_rnd      = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (exp_r < 0 || exp_r == stop_at) break;
      `CHK("valid_held", bus.rk_valid, 1'b1)
      if (stalled) begin
        `CHK("stall_rk_out", bus.rk_out, h_out)
        `CHK("stall_rk_round", bus.rk_round, h_rnd)
      end
      if (mode == 0) rdy = 1'b1;
      else if (bus.rk_round == 4'd6 && stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else rdy = 1'($urandom_range(0, 1));
      bus.start  = inject && (exp_r == 7);
      bus.key_in = 128'h00112233445566778899aabbccddeeff ^ 128'(cyc);
      bus.rk_ready = rdy;
      if (rdy && bus.rk_valid) begin
        `CHK("rk_round", bus.rk_round, 4'(exp_r))
        if (exp_known[exp_r]) `CHK("rk_out", bus.rk_out, exp_rk[exp_r])
        exp_r--;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        h_out   = bus.rk_out;
        h_rnd   = bus.rk_round;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    if (stop_at < 0) begin
      `CHK("all_keys_seen", exp_r, -1)
      bus.rk_ready = 1'b0;
      `CHK("done_pulse", bus.done, 1'b1)
      `CHK("busy_in_fin", bus.busy, 1'b1)
      `CHK("valid_in_fin", bus.rk_valid, 1'b0)
      if (inject) begin
        bus.start  = 1'b1;
        bus.key_in = 128'hffeeddccbbaa99887766554433221100;
      end
      @(negedge clk);
      bus.start = 1'b0;
      `CHK("done_low", bus.done, 1'b0)
      `CHK("busy_low", bus.busy, 1'b0)
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.key_in   = '0;
    bus.rk_ready = 1'b0;
    #12;
    tests++;
    if (bus.busy !== 1'b0 || bus.rk_valid !== 1'b0 || bus.rk_out !== 128'h0 ||
        bus.rk_round !== 4'h0 || bus.done !== 1'b0) begin
      fails++;
      $error("FAIL rst_state busy=%0b valid=%0b rk_out=%0h rk_round=%0h done=%0b",
             bus.busy, bus.rk_valid, bus.rk_out, bus.rk_round, bus.done);
    end
    `CHK("rst_busy", bus.busy, 1'b0)
    `CHK("rst_valid", bus.rk_valid, 1'b0)
    `CHK("rst_rk_out", bus.rk_out, 128'h0)
    `CHK("rst_rk_round", bus.rk_round, 4'h0)
    `CHK("rst_done", bus.done, 1'b0)
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 key, consumer always ready
    load_fips();
    start_seq(FIPS_KEY, 1'b0);
    collect(0, -1, 1'b0);

    // Same key under random backpressure
    start_seq(FIPS_KEY, 1'b0);
    collect(1, -1, 1'b0);

    // All-zero key
    load_zero();
    start_seq(ZERO_KEY, 1'b0);
    collect(0, -1, 1'b0);

    // Spurious starts in FWD, REV and FIN
    load_fips();
    start_seq(FIPS_KEY, 1'b1);
    collect(0, -1, 1'b1);

    // Reset while round 4 is on offer
    start_seq(FIPS_KEY, 1'b0);
    collect(0, 4, 1'b0);
    `CHK("pre_rst_round", bus.rk_round, 4'd4)
    bus.rk_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    `CHK("mid_rst_busy", bus.busy, 1'b0)
    `CHK("mid_rst_valid", bus.rk_valid, 1'b0)
    `CHK("mid_rst_rk_out", bus.rk_out, 128'h0)
    `CHK("mid_rst_rk_round", bus.rk_round, 4'h0)
    `CHK("mid_rst_done", bus.done, 1'b0)
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    `CHK("post_rst_busy", bus.busy, 1'b0)
    `CHK("post_rst_valid", bus.rk_valid, 1'b0)
    start_seq(FIPS_KEY, 1'b0);
    collect(0, -1, 1'b0);

    // Back-to-back: start in the first IDLE cycle after done, different key
    load_zero();
    start_seq(ZERO_KEY, 1'b0);
    collect(0, -1, 1'b0);
    load_fips();
    start_seq(FIPS_KEY, 1'b0);
    collect(0, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
